// File: rtl/lowpass_pkg.sv
`default_nettype none
// ============================================================================
// Module : lowpass_pkg
// Shared constants, FSM state type and Q1.15 lowpass coefficient set.
// Rev    : 1.0
// ============================================================================
package lowpass_pkg;

    localparam int c_sample_w = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    // Hamming-windowed sinc, fc ~8 kHz at fs 48 kHz; taps sum to 32767.
    localparam logic signed [15:0] LP_COEF [16] = '{
        16'sd111,   16'sd96,    -16'sd219,  -16'sd917,
        -16'sd874,  16'sd1598,  16'sd6312,  16'sd10278,
        16'sd10275, 16'sd6312,  16'sd1598,  -16'sd874,
        -16'sd917,  -16'sd219,  16'sd96,    16'sd111
    };

endpackage
`default_nettype wire

// File: rtl/lowpass_rr_arb.sv
`default_nettype none
// ============================================================================
// Module : lowpass_rr_arb
// Round-robin grant: lowest requesting index after the last-served channel.
// Rev    : 1.0
// ============================================================================
module lowpass_rr_arb #(
    parameter  int CHANNELS = 2,
    localparam int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] req,
    input  logic                en,
    input  logic                upd,
    output logic [CHANNELS-1:0] gnt,
    output logic [CW-1:0]       gnt_idx
);

    logic [CW-1:0] r_last;
    logic [CW-1:0] w_idx;
    logic          w_found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int i = 1; i <= CHANNELS; i++) begin
            w_idx = CW'((int'(r_last) + i) % CHANNELS);
            if (en && !w_found && req[w_idx]) begin
                w_found    = 1'b1;
                gnt[w_idx] = 1'b1;
                gnt_idx    = w_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last <= CW'(CHANNELS - 1);
        end else if (upd) begin
            r_last <= gnt_idx;
        end
    end

endmodule
`default_nettype wire

// File: rtl/lowpass_mac_sched.sv
`default_nettype none
// ============================================================================
// Module : lowpass_mac_sched
// One shared 16x16 MAC time-multiplexed over CHANNELS FIR lowpass filters.
// Define LOWPASS_SAT_EN to saturate the output instead of wrapping it.
// Rev    : 1.0
// ============================================================================
module lowpass_mac_sched
    import lowpass_pkg::*;
#(
    parameter  int CHANNELS   = 2,
    parameter  int TAPS       = 16,
    parameter  int GAIN_SHIFT = 15,
    localparam int CW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [CHANNELS-1:0]          in_valid,
    input  logic [CHANNELS*c_sample_w-1:0] in_data,
    output logic [CHANNELS-1:0]          in_ready,
    output logic                         out_valid,
    output logic [c_sample_w-1:0]        out_data,
    output logic [CW-1:0]                out_chan,
    input  logic                         out_ready
);

    localparam int TW = $clog2(TAPS);
    localparam int AW = 32 + TW;

    state_t                        r_state;
    state_t                        w_state_nxt;
    logic [CHANNELS-1:0]           w_gnt;
    logic [CW-1:0]                 w_gnt_idx;
    logic                          w_idle;
    logic                          w_accept;
    logic                          w_last_tap;
    logic signed [c_sample_w-1:0]  r_dl [CHANNELS][TAPS];
    logic [TW-1:0]                 r_wp [CHANNELS];
    logic [CW-1:0]                 r_chan;
    logic [TW-1:0]                 r_tap;
    logic [TW-1:0]                 r_newest;
    logic signed [AW-1:0]          r_acc;
    logic signed [AW-1:0]          w_shift;
    logic signed [31:0]            w_prod;
    logic signed [c_sample_w-1:0]  w_x;
    logic signed [c_sample_w-1:0]  w_in_sample;
    logic [c_sample_w-1:0]         w_result;
    logic                          r_out_valid;
    logic [c_sample_w-1:0]         r_out_data;
    logic [CW-1:0]                 r_out_chan;

    assign w_idle = (r_state == IDLE);

    lowpass_rr_arb #(
        .CHANNELS (CHANNELS)
    ) u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (in_valid),
        .en      (w_idle),
        .upd     (w_accept),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx)
    );

    assign w_accept    = |(in_valid & w_gnt);
    assign in_ready    = reset_n ? w_gnt : '0;
    assign w_in_sample = in_data[int'(w_gnt_idx)*c_sample_w +: c_sample_w];

    // Tap t multiplies the sample written t accepts ago on this channel.
    assign w_x        = r_dl[r_chan][r_newest - r_tap];
    assign w_prod     = LP_COEF[r_tap] * w_x;
    assign w_last_tap = (r_tap == TW'(TAPS - 1));
    assign w_shift    = r_acc >>> GAIN_SHIFT;

    always_comb begin
        w_result = w_shift[c_sample_w-1:0];
`ifdef LOWPASS_SAT_EN
        if (!((&w_shift[AW-1:c_sample_w-1]) || (~|w_shift[AW-1:c_sample_w-1]))) begin
            w_result = w_shift[AW-1] ? 16'h8000 : 16'h7FFF;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = MAC;
            MAC:     if (w_last_tap) w_state_nxt = OUT;
            OUT:     if (r_out_valid && out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < CHANNELS; c++) begin
                r_wp[c] <= '0;
                for (int t = 0; t < TAPS; t++) begin
                    r_dl[c][t] <= '0;
                end
            end
            r_chan      <= '0;
            r_tap       <= '0;
            r_newest    <= '0;
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_chan  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_dl[w_gnt_idx][r_wp[w_gnt_idx]] <= w_in_sample;
                        r_wp[w_gnt_idx] <= r_wp[w_gnt_idx] + TW'(1);
                        r_newest        <= r_wp[w_gnt_idx];
                        r_chan          <= w_gnt_idx;
                        r_acc           <= '0;
                        r_tap           <= '0;
                    end
                end
                MAC: begin
                    r_acc <= r_acc + AW'(w_prod);
                    r_tap <= r_tap + TW'(1);
                end
                OUT: begin
                    // First OUT cycle registers the result; the output then holds until taken.
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_result;
                        r_out_chan  <= r_chan;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_chan  = r_out_chan;

endmodule
`default_nettype wire

// File: tb/tb_lowpass_mac_sched.sv
`default_nettype none
// ============================================================================
// Module : tb_lowpass_mac_sched
// Scoreboard bench: FIR reference model per channel, decoupled output monitor.
// Rev    : 1.0
// ============================================================================
module tb_lowpass_mac_sched;
    import lowpass_pkg::*;

    localparam int CHANNELS   = 2;
    localparam int TAPS       = 16;
    localparam int GAIN_SHIFT = 15;
    localparam int CW         = 1;

    logic                     clk = 1'b0;
    logic                     reset_n = 1'b0;
    logic [CHANNELS-1:0]      in_valid = '0;
    logic [CHANNELS*16-1:0]   in_data = '0;
    logic [CHANNELS-1:0]      in_ready;
    logic                     out_valid;
    logic [15:0]              out_data;
    logic [CW-1:0]            out_chan;
    logic                     out_ready = 1'b1;
    int                       bp_mode = 0;

    lowpass_mac_sched #(
        .CHANNELS   (CHANNELS),
        .TAPS       (TAPS),
        .GAIN_SHIFT (GAIN_SHIFT)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (bp_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b0;
        endcase
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: per-channel history, newest sample at index 0.
    typedef struct {
        int chan;
        int data;
        int edge_n;
    } exp_t;

    exp_t q[$];
    int   hist [CHANNELS][TAPS];
    int   tb_last = CHANNELS - 1;

    function automatic int model_out(input int c);
        longint      s;
        longint      sh;
        logic [63:0] t;
        s = 0;
        for (int k = 0; k < TAPS; k++) s += longint'(LP_COEF[k]) * longint'(hist[c][k]);
        sh = s >>> GAIN_SHIFT;
`ifdef LOWPASS_SAT_EN
        if (sh > 32767)  return 32767;
        if (sh < -32768) return -32768;
        return int'(sh);
`else
        t = sh;
        return int'($signed(t[15:0]));
`endif
    endfunction

    task automatic model_reset();
        q.delete();
        for (int c = 0; c < CHANNELS; c++)
            for (int k = 0; k < TAPS; k++) hist[c][k] = 0;
        tb_last = CHANNELS - 1;
    endtask

    // Accept monitor: feeds the model and the scoreboard queue.
    int a_c;
    int a_e;
    always @(negedge clk) begin
        if (reset_n && |(in_valid & in_ready)) begin
            chk("in_ready_onehot", $onehot0(in_ready), 1);
            a_c = 0;
            for (int c = CHANNELS - 1; c >= 0; c--) if (in_valid[c] && in_ready[c]) a_c = c;
            a_e = -1;
            for (int i = CHANNELS; i >= 1; i--) if (in_valid[(tb_last + i) % CHANNELS]) a_e = (tb_last + i) % CHANNELS;
            chk("grant_round_robin", a_c, a_e);
            for (int k = TAPS - 1; k > 0; k--) hist[a_c][k] = hist[a_c][k-1];
            hist[a_c][0] = int'($signed(in_data[a_c*16 +: 16]));
            q.push_back('{chan: a_c, data: model_out(a_c), edge_n: cyc + 1});
            tb_last = a_c;
        end
        if (reset_n && out_valid) chk("no_grant_while_output_pending", in_ready, 0);
    end

    // Output monitor: pops the scoreboard on each new output.
    logic        hold = 1'b0;
    logic        hs_prev = 1'b0;
    logic [15:0] held_d = '0;
    logic [CW-1:0] held_c = '0;
    exp_t        m_e;
    always @(negedge clk) begin
        if (!reset_n) begin
            hold    = 1'b0;
            hs_prev = 1'b0;
        end else begin
            if (hs_prev) begin
                chk("valid_drops_after_handshake", out_valid, 0);
            end else if (hold) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, held_d);
                chk("stall_chan", out_chan, held_c);
            end else if (out_valid) begin
                if (q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_output: got data %0d chan %0d, required no output", $signed(out_data), out_chan);
                end else begin
                    m_e = q.pop_front();
                    chk("out_data", $signed(out_data), m_e.data);
                    chk("out_chan", out_chan, m_e.chan);
                    chk("accept_to_valid_latency", cyc, m_e.edge_n + TAPS + 1);
                end
            end
            hold    = out_valid && !out_ready;
            hs_prev = out_valid && out_ready;
            held_d  = out_data;
            held_c  = out_chan;
        end
    end

    // Presents samples on the masked channels and holds each until accepted.
    task automatic issue(input logic [CHANNELS-1:0] mask, input logic [CHANNELS*16-1:0] data);
        logic [CHANNELS-1:0] pend;
        logic [CHANNELS-1:0] w;
        int                  t;
        pend = mask;
        t    = 0;
        @(posedge clk);
        #1;
        in_data  = data;
        in_valid = mask;
        while (pend != 0 && t < 400) begin
            @(negedge clk);
            w = in_valid & in_ready;
            if (w != 0) begin
                @(posedge clk);
                #1;
                pend     = pend & ~w;
                in_valid = pend;
            end
            t++;
        end
        if (pend != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL grant_timeout: pending mask %b, required 0", pend);
            in_valid = '0;
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((q.size() != 0 || out_valid) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain_timeout: %0d outputs outstanding, required 0", q.size());
        end
    endtask

    function automatic logic [15:0] rnd16();
        case ($urandom_range(0, 3))
            0:       return 16'h7FFF;
            1:       return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        model_reset();
        in_valid = 2'b11;
        in_data  = {16'h1234, 16'h5678};
        repeat (3) @(negedge clk);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_data", out_data, 0);
        chk("reset_out_chan", out_chan, 0);
        chk("reset_in_ready", in_ready, 0);
        @(posedge clk);
        #1 in_valid = '0;
        #1 reset_n = 1'b1;

        // Impulse on channel 0.
        issue(2'b01, {16'h0000, 16'h7FFF});
        repeat (TAPS + 1) issue(2'b01, '0);

        // DC step on channel 1, then channel 0 must still be silent.
        repeat (TAPS + 4) issue(2'b10, {16'h7FFF, 16'h0000});
        repeat (3) issue(2'b01, '0);

        // Both channels requesting: grants must alternate.
        repeat (6) issue(2'b11, {16'($urandom), 16'($urandom)});

        // Sign-matched full-scale inputs drive the accumulator past 16 bits.
        for (int k = TAPS - 1; k >= 0; k--) begin
            if (LP_COEF[k] < 0) issue(2'b11, {16'h8000, 16'h7FFF});
            else                issue(2'b11, {16'h7FFF, 16'h8000});
        end

        // Random traffic under random backpressure.
        bp_mode = 1;
        repeat (40) issue(CHANNELS'($urandom_range(1, 3)), {rnd16(), rnd16()});
        wait_drain();
        bp_mode = 0;

        // Held backpressure for more than 20 cycles with both channels waiting.
        @(posedge clk);
        bp_mode = 2;
        fork
            issue(2'b11, {rnd16(), rnd16()});
            begin
                repeat (TAPS + 24) @(posedge clk);
                bp_mode = 0;
            end
        join
        wait_drain();

        // Reset in the middle of the MAC sequence.
        issue(2'b01, {16'h0000, 16'h4000});
        repeat (5) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("midmac_reset_out_valid", out_valid, 0);
        chk("midmac_reset_in_ready", in_ready, 0);
        model_reset();
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        issue(2'b01, {16'h0000, 16'h7FFF});
        repeat (TAPS + 1) issue(2'b01, '0);
        wait_drain();

        chk("scoreboard_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/lowpass_mac_sched.md
# lowpass_mac_sched

Time-multiplexed controller that shares one 16x16 multiply-accumulate datapath between CHANNELS audio lowpass FIR filters. Per-channel input samples arrive on valid/ready handshakes and are granted round-robin. For each granted sample the block writes the sample into that channel's circular delay line, sequences TAPS MAC cycles against the shared coefficient set, then presents one filtered 16-bit sample with its channel tag. It sits between the codec sample interface (48 kHz) and the downstream channel-strip stages.

## Interface
- CHANNELS, 2: number of independent filter channels (≥1).
- TAPS, 16: FIR length, power of two, ≥2.
- GAIN_SHIFT, 15: arithmetic right shift applied to the accumulator (coefficients are Q1.15).
- clk  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  CHANNELS  per-channel sample request.
- in_data  in  CHANNELS×16  per-channel signed sample, packed with channel c at bits [16c+15:16c].
- in_ready  out  CHANNELS  grant; at most one bit high.
- out_valid  out  1  filtered sample available.
- out_data  out  16  signed filtered sample.
- out_chan  out  $clog2(CHANNELS) (min 1)  channel of out_data.
- out_ready  in  1  downstream accepts the output.

## Operation
- FSM states IDLE, MAC, OUT.
- IDLE:
  - Round-robin arbiter grants the lowest-index requesting channel after the last-served channel. in_ready[g] is combinational, high only in IDLE for the granted channel.
  - On in_valid[g] & in_ready[g]: write in_data[g] at wp[g], advance wp[g] (mod TAPS), clear acc, set tap=0, latch g, go to MAC, record g as last served.
- MAC, one tap per cycle:
  - acc += LP_COEF[tap] * x_g[(newest − tap) mod TAPS].
  - tap goes 0..TAPS−1. After the tap = TAPS−1 cycle, go to OUT.
- OUT:
  - out_valid=1. out_data and out_chan are registered and held stable until out_valid & out_ready, then return to IDLE.
  - No new sample is accepted while in MAC or OUT.
- Arithmetic:
  - Product is 32-bit signed.
  - acc is 32+$clog2(TAPS) bits signed.
  - result = acc >>> GAIN_SHIFT (truncation toward −∞), then reduced to 16 bits (see Configuration).
- Delay lines: CHANNELS×TAPS×16 registers. Each channel has its own wp; the coefficient set is shared by all channels.
- Reset values:
  - State IDLE.
  - out_valid=0, out_data=0, out_chan=0, in_ready=0 while reset_n=0.
  - All delay lines and wp cleared to 0; last-served pointer set to CHANNELS−1, so channel 0 wins first.
  - acc and tap cleared.
- Reset mid-MAC or mid-OUT abandons the computation. The pending output is lost. Delay lines are cleared.
- A requester must hold in_valid and in_data until granted; the block never drops a held request.

## Timing
- Accept edge E: output appears with out_valid high after edge E+TAPS+1.
- With out_ready held high, the handshake completes on edge E+TAPS+2 and the next accept can occur at edge E+TAPS+3 at the earliest.
- Worst-case per-sample occupancy is TAPS+3 cycles.
- Requirement: f_clk ≥ 48000·CHANNELS·(TAPS+3). The default configuration needs 1.824 MHz minimum.
- Backpressure on out_ready stalls the whole block. No input is granted during the stall.

## Configuration
- LOWPASS_SAT_EN defined: the shifted result is saturated to [−32768, 32767].
- LOWPASS_SAT_EN undefined: the low 16 bits of the shifted result are taken (two's-complement wrap).

## Structure
- Package lowpass_pkg holds:
  - Sample width constant (16).
  - FSM state enum.
  - LP_COEF: TAPS-entry signed 16-bit Q1.15 coefficient array (windowed-sinc lowpass, ~8 kHz cutoff at 48 kHz, sum = 32767).
- Sub-module lowpass_rr_arb: round-robin grant over CHANNELS request lines. It takes a grant-enable input (IDLE) and an update strobe (accept).

## Test plan
- Impulse, channel 0: in_data=16'sh7FFF once, then 0s. Required: output k = (32767·LP_COEF[k]) >>> 15 for k=0..TAPS−1, then 0.
- DC step, channel 1: 32767 held for TAPS+4 samples. Required: final outputs equal (32767·32767) >>> 15 = 32766. Channel 0 outputs stay 0, proving delay-line isolation.
- Arbitration: both in_valid held high. Required: grants alternate 0,1,0,1 with out_chan matching. Each accept-to-out_valid distance is exactly TAPS+1 edges.
- Saturation, GAIN_SHIFT=14: DC −32768. Required: out_data=−32768 with LOWPASS_SAT_EN. Without it, out_data equals the low 16 bits of the shifted sum.
- Backpressure: out_ready low for 20 cycles. Required: out_valid, out_data and out_chan stay stable and in_ready stays 0 throughout. The output completes one cycle after out_ready rises.
- Reset mid-MAC: assert reset_n=0 at tap 5. Required: out_valid=0 immediately. After release, an impulse reproduces the clean impulse response.
